// File: rtl/tt_ctrl_sel_drv_pkg.sv
// rtl/tt_ctrl_sel_drv_pkg.sv - shared widths and FSM state encodings for the design-select driver
package tt_ctrl_sel_drv_pkg;

  localparam int TT_SEL_ADDR_W = 10;

  // Numeric encodings kept as localparams so a bench-side pin decoder can name them.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RST_LO = 3'd1;
  localparam logic [2:0] ST_RST_HI = 3'd2;
  localparam logic [2:0] ST_INC_HI = 3'd3;
  localparam logic [2:0] ST_INC_LO = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RST_LO = ST_RST_LO,
    S_RST_HI = ST_RST_HI,
    S_INC_HI = ST_INC_HI,
    S_INC_LO = ST_INC_LO,
    S_FIN    = ST_FIN
  } state_e;

endpackage

// File: rtl/tt_ctrl_sel_drv_if.sv
// rtl/tt_ctrl_sel_drv_if.sv - select-request handshake between host and driver
interface tt_ctrl_sel_drv_if #(
  parameter int ADDR_W = tt_ctrl_sel_drv_pkg::TT_SEL_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;

  modport master (output req_valid, req_addr, req_ena, input req_ready);
  modport slave  (input req_valid, req_addr, req_ena, output req_ready);
endinterface

// File: rtl/tt_sel_phase_timer.sv
// rtl/tt_sel_phase_timer.sv - DIV-loadable down-counter timing each waveform phase
module tt_sel_phase_timer #(
  parameter int DIV = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic zero_o
);
  localparam int W = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(DIV);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/tt_ctrl_sel_drv.sv
// rtl/tt_ctrl_sel_drv.sv - drives tt_ctrl select pins: reset counter, pulse increment N times, set enable
// Optional macro TT_SEL_DRV_INCR_EN: skip the reset phases when the target is reachable by counting up.
module tt_ctrl_sel_drv
  import tt_ctrl_sel_drv_pkg::*;
#(
  parameter int ADDR_W = TT_SEL_ADDR_W,
  parameter int DIV    = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tt_ctrl_sel_drv_if.slave    req,
  output logic                busy_o,
  output logic                done_o,
  output logic [ADDR_W-1:0]   cur_addr_o,
  output logic                cur_valid_o,
  output logic                sel_rst_n_o,
  output logic                sel_inc_o,
  output logic                ena_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q, tgt_q, cur_addr_q;
  logic              ena_req_q, busy_q, done_q, cur_valid_q;
  logic              sel_rst_n_q, sel_inc_q, ena_q;
  logic              tmr_zero, tmr_load, accept;
  logic              skip_rst_d;
  logic [ADDR_W-1:0] n_d;

  assign req.req_ready = (state_q == S_IDLE);
  assign accept        = req.req_valid && (state_q == S_IDLE);
  // Keep reloading while idle so the first phase after accept starts at DIV.
  assign tmr_load      = (state_q == S_IDLE) || tmr_zero;

`ifdef TT_SEL_DRV_INCR_EN
  assign skip_rst_d = cur_valid_q && (req.req_addr >= cur_addr_q);
  assign n_d        = skip_rst_d ? (req.req_addr - cur_addr_q) : req.req_addr;
`else
  assign skip_rst_d = 1'b0;
  assign n_d        = req.req_addr;
`endif

  tt_sel_phase_timer #(.DIV(DIV)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      ena_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      sel_rst_n_q <= 1'b1;
      sel_inc_q   <= 1'b0;
      ena_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tgt_q     <= req.req_addr;
            ena_req_q <= req.req_ena;
            cnt_q     <= n_d;
            busy_q    <= 1'b1;
            ena_q     <= 1'b0;
            if (!skip_rst_d) begin
              state_q     <= S_RST_LO;
              sel_rst_n_q <= 1'b0;
            end else if (n_d != '0) begin
              state_q   <= S_INC_HI;
              sel_inc_q <= 1'b1;
            end else begin
              // Already at the target: finish without touching the select pins.
              state_q     <= S_FIN;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              ena_q       <= req.req_ena;
              cur_addr_q  <= req.req_addr;
              cur_valid_q <= 1'b1;
            end
          end
        end
        S_RST_LO: begin
          if (tmr_zero) begin
            state_q     <= S_RST_HI;
            sel_rst_n_q <= 1'b1;
          end
        end
        S_RST_HI, S_INC_LO: begin
          if (tmr_zero) begin
            if (cnt_q == '0) begin
              state_q     <= S_FIN;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              ena_q       <= ena_req_q;
              cur_addr_q  <= tgt_q;
              cur_valid_q <= 1'b1;
            end else begin
              state_q   <= S_INC_HI;
              sel_inc_q <= 1'b1;
            end
          end
        end
        S_INC_HI: begin
          if (tmr_zero) begin
            state_q   <= S_INC_LO;
            sel_inc_q <= 1'b0;
            cnt_q     <= cnt_q - ADDR_W'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cur_addr_o  = cur_addr_q;
  assign cur_valid_o = cur_valid_q;
  assign sel_rst_n_o = sel_rst_n_q;
  assign sel_inc_o   = sel_inc_q;
  assign ena_o       = ena_q;

endmodule

// File: tb/tb_tt_ctrl_sel_drv.sv
// tb/tb_tt_ctrl_sel_drv.sv - directed bench for tt_ctrl_sel_drv with a pin-level tt_ctrl counter model
module tb_tt_ctrl_sel_drv;
  localparam int AW  = 10;
  localparam int DIV = 3;

`ifdef TT_SEL_DRV_INCR_EN
  localparam int E1023 = 8145, P1023 = 1018;
  localparam int E5 = 25, R5 = 0, P5 = 3;
  localparam int E8 = 25, R8 = 0, P8 = 3;
  localparam int E88 = 1, R88 = 0, P88 = 0;
`else
  localparam int E1023 = 8193, P1023 = 1023;
  localparam int E5 = 49, R5 = 4, P5 = 5;
  localparam int E8 = 73, R8 = 4, P8 = 8;
  localparam int E88 = 73, R88 = 4, P88 = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_ctrl_sel_drv_if #(.ADDR_W(AW)) bus ();

  logic          busy, done, cur_valid, sel_rst_n, sel_inc, ena;
  logic [AW-1:0] cur_addr;

  tt_ctrl_sel_drv #(.ADDR_W(AW), .DIV(DIV)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .cur_addr_o  (cur_addr),
    .cur_valid_o (cur_valid),
    .sel_rst_n_o (sel_rst_n),
    .sel_inc_o   (sel_inc),
    .ena_o       (ena)
  );

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] model_cnt;
  logic          prev_inc;
  int            done_cyc, rst_lo_first, rst_lo_cnt, pulses, inc_hi, ready_seen;
  logic          busy1, ena_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [AW-1:0] addr, input logic e);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_ena   = e;
  endtask

  // Watches up to max cycles after the accept edge, feeding the tt_ctrl counter model from the pins.
  task automatic monitor(input int max, input bit drop_valid, input logic [AW-1:0] alt_addr, input logic alt_ena);
    done_cyc = 0; rst_lo_first = 0; rst_lo_cnt = 0; pulses = 0; inc_hi = 0; ready_seen = 0;
    busy1 = 1'b0; ena_at_done = 1'b0;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        busy1 = busy;
        if (drop_valid) bus.req_valid = 1'b0;
        else begin bus.req_addr = alt_addr; bus.req_ena = alt_ena; end
      end
      if (!sel_rst_n) begin
        model_cnt = '0;
        rst_lo_cnt++;
        if (rst_lo_first == 0) rst_lo_first = c;
      end else if (sel_inc && !prev_inc) begin
        model_cnt = model_cnt + AW'(1);
      end
      if (sel_inc && !prev_inc) pulses++;
      if (sel_inc) inc_hi++;
      prev_inc = sel_inc;
      if (bus.req_ready) ready_seen++;
      if (done) begin
        done_cyc = c;
        ena_at_done = ena;
        break;
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_ena = 1'b0;
    model_cnt = '0; prev_inc = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel_rst_n", sel_rst_n, 1);
    check("rst_sel_inc", sel_inc, 0);
    check("rst_ena", ena, 0);
    check("rst_cur_addr", cur_addr, 0);
    check("rst_cur_valid", cur_valid, 0);

    // addr 0: reset phases only
    send(0, 1'b1);
    monitor(40, 1'b1, '0, 1'b0);
    check("a0_done_cyc", done_cyc, 9);
    check("a0_rst_lo_first", rst_lo_first, 1);
    check("a0_rst_lo_cnt", rst_lo_cnt, 4);
    check("a0_pulses", pulses, 0);
    check("a0_busy_c1", busy1, 1);
    check("a0_ena", ena_at_done, 1);
    check("a0_cur_addr", cur_addr, 0);
    check("a0_cur_valid", cur_valid, 1);
    @(posedge clk); #1;
    check("a0_idle_ready", bus.req_ready, 1);
    check("a0_idle_done", done, 0);
    check("a0_idle_busy", busy, 0);
    check("a0_ena_hold", ena, 1);

    // addr 5 from a cleared status: full sequence
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    check("a5_pre_cur_valid", cur_valid, 0);
    send(5, 1'b1);
    monitor(100, 1'b1, '0, 1'b0);
    check("a5_done_cyc", done_cyc, 49);
    check("a5_rst_lo_cnt", rst_lo_cnt, 4);
    check("a5_pulses", pulses, 5);
    check("a5_inc_hi", inc_hi, 20);
    check("a5_cur_addr", cur_addr, 5);
    check("a5_model", model_cnt, 5);
    check("a5_ena", ena_at_done, 1);

    // maximum address: 1023 pulses, no wrap
    @(posedge clk); #1;
    send(10'd1023, 1'b0);
    monitor(9000, 1'b1, '0, 1'b0);
    check("amax_done_cyc", done_cyc, E1023);
    check("amax_pulses", pulses, P1023);
    check("amax_model", model_cnt, 1023);
    check("amax_cur_addr", cur_addr, 1023);
    check("amax_ena", ena_at_done, 0);

    // abort mid-sequence
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    send(5, 1'b1);
    monitor(20, 1'b1, '0, 1'b0);
    check("abort_pre_inc", sel_inc, 1);
    check("abort_pre_done", done_cyc, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_sel_inc", sel_inc, 0);
    check("abort_sel_rst_n", sel_rst_n, 1);
    check("abort_ena", ena, 0);
    check("abort_cur_valid", cur_valid, 0);
    check("abort_ready", bus.req_ready, 1);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    prev_inc = 1'b0;

    // request held through a sequence with a new address
    @(posedge clk); #1;
    send(3, 1'b1);
    monitor(60, 1'b0, 2, 1'b0);
    check("hold1_done_cyc", done_cyc, 33);
    check("hold1_no_ready", ready_seen, 0);
    check("hold1_cur_addr", cur_addr, 3);
    @(posedge clk); #1;
    check("hold_idle_ready", bus.req_ready, 1);
    monitor(60, 1'b1, '0, 1'b0);
    check("hold2_done_cyc", done_cyc, 25);
    check("hold2_rst_lo_cnt", rst_lo_cnt, 4);
    check("hold2_pulses", pulses, 2);
    check("hold2_cur_addr", cur_addr, 2);
    check("hold2_ena", ena_at_done, 0);
    check("hold2_model", model_cnt, 2);

    // upward, repeated and downward targets
    @(posedge clk); #1;
    send(5, 1'b1);
    monitor(100, 1'b1, '0, 1'b0);
    check("up5_done_cyc", done_cyc, E5);
    check("up5_rst_lo_cnt", rst_lo_cnt, R5);
    check("up5_pulses", pulses, P5);
    check("up5_model", model_cnt, 5);
    @(posedge clk); #1;
    send(8, 1'b1);
    monitor(100, 1'b1, '0, 1'b0);
    check("up8_done_cyc", done_cyc, E8);
    check("up8_rst_lo_cnt", rst_lo_cnt, R8);
    check("up8_pulses", pulses, P8);
    check("up8_model", model_cnt, 8);
    check("up8_cur_addr", cur_addr, 8);
    @(posedge clk); #1;
    send(8, 1'b0);
    monitor(100, 1'b1, '0, 1'b0);
    check("same8_done_cyc", done_cyc, E88);
    check("same8_rst_lo_cnt", rst_lo_cnt, R88);
    check("same8_pulses", pulses, P88);
    check("same8_ena", ena_at_done, 0);
    @(posedge clk); #1;
    send(2, 1'b1);
    monitor(100, 1'b1, '0, 1'b0);
    check("down2_done_cyc", done_cyc, 25);
    check("down2_rst_lo_cnt", rst_lo_cnt, 4);
    check("down2_pulses", pulses, 2);
    check("down2_model", model_cnt, 2);
    check("down2_ena", ena_at_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
